// File: rtl/stream_pad2d_if.sv
// Valid/ready stream bundle for stream_pad2d.
// Slave side is the padding block, master side drives it.
interface stream_pad2d_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  valid_in;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last_out;
  logic                  busy;

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_out,
    output ready_in,
    output valid_out,
    output data_out,
    output last_out,
    output busy
  );

  modport master (
    output valid_in,
    output data_in,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  data_out,
    input  last_out,
    input  busy
  );
endinterface

// File: rtl/stream_pad2d.sv
// Raster-stream 2D padding stage: wraps each IMG_W x IMG_H x CHANNELS
// frame in a PAD-wide border of PAD_VAL under full valid/ready flow control.
module stream_pad2d #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int CHANNELS   = 1,
  parameter int PAD        = 1,
  parameter logic signed [DATA_WIDTH-1:0] PAD_VAL = '0
) (
  input logic           clk,
  input logic           rst_n,
  stream_pad2d_if.slave bus
);

  localparam int OW  = IMG_W + 2 * PAD;
  localparam int OH  = IMG_H + 2 * PAD;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CLW = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW  = (OH > 1) ? $clog2(OH) : 1;

  localparam logic [CW-1:0]  CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(OW - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(OH - 1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]  r_ch;
  logic [CLW-1:0] r_col;
  logic [RW-1:0]  r_row;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  logic w_active;
  logic w_col_in;
  logic w_row_in;
  logic w_interior;
  logic w_slot_free;
  logic w_ready;
  logic w_load;
  logic w_ch_last;
  logic w_col_last;
  logic w_end;

  generate
    if (PAD == 0) begin : g_nopad
      assign w_col_in = 1'b1;
      assign w_row_in = 1'b1;
    end else begin : g_pad
      localparam logic [CLW-1:0] COL_LO = CLW'(PAD);
      localparam logic [CLW-1:0] COL_HI = CLW'(PAD + IMG_W - 1);
      localparam logic [RW-1:0]  ROW_LO = RW'(PAD);
      localparam logic [RW-1:0]  ROW_HI = RW'(PAD + IMG_H - 1);
      assign w_col_in = (r_col >= COL_LO) && (r_col <= COL_HI);
      assign w_row_in = (r_row >= ROW_LO) && (r_row <= ROW_HI);
    end
  endgenerate

  assign w_active    = (r_state == S_ACTIVE);
  assign w_interior  = w_col_in & w_row_in;
  assign w_slot_free = !r_valid | bus.ready_out;
  assign w_ready     = w_active & w_interior & w_slot_free;
  // Border loads never wait on input; interior loads need a sample.
  assign w_load      = w_active & w_slot_free
                     & (!w_interior | bus.valid_in);

  assign w_ch_last  = (r_ch == CH_LAST);
  assign w_col_last = (r_col == COL_LAST);
  assign w_end      = w_ch_last & w_col_last
                    & (r_row == ROW_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.valid_in) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_load && w_end) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch  <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (w_load) begin
      if (w_end) begin
        r_ch  <= '0;
        r_col <= '0;
        r_row <= '0;
      end else if (w_ch_last) begin
        r_ch <= '0;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CLW'(1);
        end
      end else begin
        r_ch <= r_ch + CW'(1);
      end
    end
  end

  // Output slot holds its sample until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_interior ? bus.data_in : PAD_VAL;
      r_last  <= w_end;
    end else if (bus.ready_out) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.ready_in  = w_ready;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data;
  assign bus.last_out  = r_last;
  assign bus.busy      = w_active;

endmodule

// File: tb/tb_stream_pad2d.sv
// Directed bench for stream_pad2d: three configurations sharing
// one clock and reset, one active at a time through a select.
module tb_stream_pad2d;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        t_vin = 1'b0;
  logic [15:0] t_din = '0;
  logic        t_rdy = 1'b1;

  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_rin;
  logic        s_busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];
  int          vin_c;
  int          vout_c;

  stream_pad2d_if #(.DATA_WIDTH(16)) if0 ();
  stream_pad2d_if #(.DATA_WIDTH(16)) if1 ();
  stream_pad2d_if #(.DATA_WIDTH(16)) if2 ();

  stream_pad2d #(
    .DATA_WIDTH(16), .IMG_W(4), .IMG_H(4),
    .CHANNELS(1), .PAD(1), .PAD_VAL(16'h0000)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  stream_pad2d #(
    .DATA_WIDTH(16), .IMG_W(2), .IMG_H(2),
    .CHANNELS(2), .PAD(1), .PAD_VAL(16'hFFFF)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  stream_pad2d #(
    .DATA_WIDTH(16), .IMG_W(4), .IMG_H(4),
    .CHANNELS(1), .PAD(0), .PAD_VAL(16'h0000)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.valid_in  = (sel == 0) && t_vin;
  assign if1.valid_in  = (sel == 1) && t_vin;
  assign if2.valid_in  = (sel == 2) && t_vin;
  assign if0.data_in   = t_din;
  assign if1.data_in   = t_din;
  assign if2.data_in   = t_din;
  assign if0.ready_out = (sel == 0) ? t_rdy : 1'b1;
  assign if1.ready_out = (sel == 1) ? t_rdy : 1'b1;
  assign if2.ready_out = (sel == 2) ? t_rdy : 1'b1;

  always_comb begin
    s_valid = if0.valid_out;
    s_data  = if0.data_out;
    s_last  = if0.last_out;
    s_rin   = if0.ready_in;
    s_busy  = if0.busy;
    if (sel == 1) begin
      s_valid = if1.valid_out;
      s_data  = if1.data_out;
      s_last  = if1.last_out;
      s_rin   = if1.ready_in;
      s_busy  = if1.busy;
    end else if (sel == 2) begin
      s_valid = if2.valid_out;
      s_data  = if2.data_out;
      s_last  = if2.last_out;
      s_rin   = if2.ready_in;
      s_busy  = if2.busy;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs after the edge, sample at the falling edge.
  task automatic run(input int n_in, input int first,
                     input int n_out, input int rmode,
                     input int gap_after, input int stop_in);
    int idx = 0;
    int gap = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b1;
    logic [15:0] pd = '0;
    logic pl = 1'b0;
    bit go = 1'b1;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    vin_c = -1;
    vout_c = -1;
    while (go) begin
      @(posedge clk);
      #1;
      t_vin = (idx < n_in) && (gap == 0);
      if (gap > 0) gap--;
      t_din = 16'(first + idx);
      t_rdy = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge clk);
      if (t_vin && vin_c < 0) vin_c = cyc;
      if (s_valid && vout_c < 0) vout_c = cyc;
      if (pv && !pr) begin
        check("hold_valid", 32'(s_valid), 32'd1);
        check("hold_data", 32'(s_data), 32'(pd));
        check("hold_last", 32'(s_last), 32'(pl));
      end
      if (s_valid && !t_rdy)
        check("rdy_in_stall", 32'(s_rin), 32'd0);
      if (t_vin && s_rin) begin
        idx++;
        if (idx == gap_after) gap = 3;
      end
      if (s_valid && t_rdy) begin
        got_d.push_back(s_data);
        got_l.push_back(s_last);
        got_c.push_back(cyc);
      end
      pv = s_valid;
      pr = t_rdy;
      pd = s_data;
      pl = s_last;
      cyc++;
      if (stop_in > 0) go = (idx < stop_in);
      else go = (got_d.size() < n_out);
      if (cyc >= 600) go = 1'b0;
    end
    @(posedge clk);
    #1;
    t_vin = 1'b0;
    t_rdy = 1'b1;
    if (stop_in > 0) check("stop_count", 32'(idx), 32'(stop_in));
    else check("out_count", 32'(got_d.size()), 32'(n_out));
  endtask

  int exp1[36] = '{0,0,0,0,0,0,0,1,2,3,4,0,0,5,6,7,8,0,
                   0,9,10,11,12,0,0,13,14,15,16,0,0,0,0,0,0,0};
  localparam logic [15:0] M = 16'hFFFF;
  logic [15:0] exp4[32] = '{M,M,M,M,M,M,M,M,
                            M,M,16'd10,16'd11,16'd12,16'd13,M,M,
                            M,M,16'd14,16'd15,16'd16,16'd17,M,M,
                            M,M,M,M,M,M,M,M};

  task automatic cmp_frame1(input string tag);
    for (int i = 0; i < got_d.size() && i < 36; i++) begin
      check({tag, "_data"}, 32'(got_d[i]), 32'(exp1[i]));
      check({tag, "_last"}, 32'(got_l[i]), 32'(i == 35));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_valid", 32'(s_valid), 32'd0);
      check("rst_data", 32'(s_data), 32'd0);
      check("rst_last", 32'(s_last), 32'd0);
      check("rst_busy", 32'(s_busy), 32'd0);
      check("rst_rdy_in", 32'(s_rin), 32'd0);
    end
    sel = 0;
    rst_n = 1'b1;

    // 4x4 PAD=1, continuous stream
    run(16, 1, 36, 0, 0, 0);
    cmp_frame1("s1");
    check("s1_latency", 32'(vout_c - vin_c), 32'd2);
    check("s1_busy_end", 32'(s_busy), 32'd0);

    // same frame under 1,0,0,1 backpressure
    run(16, 1, 36, 1, 0, 0);
    cmp_frame1("s2");

    // input gap of 3 cycles after sample 6
    run(16, 1, 36, 0, 6, 0);
    cmp_frame1("s3");
    if (got_c.size() == 36)
      check("s3_gap_idle", 32'(got_c[15] - got_c[14] - 1), 32'd3);

    // 2x2 C=2 PAD=1 PAD_VAL=-1
    sel = 1;
    run(8, 10, 32, 0, 0, 0);
    for (int i = 0; i < got_d.size() && i < 32; i++) begin
      check("s4_data", 32'(got_d[i]), 32'(exp4[i]));
      check("s4_last", 32'(got_l[i]), 32'(i == 31));
    end

    // mid-frame reset after 5 inputs
    sel = 0;
    run(16, 1, 0, 0, 0, 5);
    check("s5_pre_data", 32'(s_data), 32'd5);
    check("s5_pre_busy", 32'(s_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("s5_rst_valid", 32'(s_valid), 32'd0);
    check("s5_rst_data", 32'(s_data), 32'd0);
    check("s5_rst_last", 32'(s_last), 32'd0);
    check("s5_rst_busy", 32'(s_busy), 32'd0);
    rst_n = 1'b1;
    run(16, 1, 36, 0, 0, 0);
    cmp_frame1("s5");
    check("s5_latency", 32'(vout_c - vin_c), 32'd2);

    // PAD=0 pass-through, two frames back to back
    sel = 2;
    run(32, 1, 32, 0, 0, 0);
    for (int i = 0; i < got_d.size() && i < 32; i++) begin
      check("s6_data", 32'(got_d[i]), 32'(i + 1));
      check("s6_last", 32'(got_l[i]),
            32'((i == 15) || (i == 31)));
    end
    if (got_c.size() == 32) begin
      check("s6_bubble", 32'(got_c[16] - got_c[15] - 1), 32'd1);
      check("s6_stream", 32'(got_c[15] - got_c[0]), 32'd15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_pad2d.md
# stream_pad2d

Parametrised zero/constant padding stage for raster-streamed feature maps in the FI-GAN generator datapath. It takes one IMG_W×IMG_H×CHANNELS frame and emits an (IMG_W+2·PAD)×(IMG_H+2·PAD)×CHANNELS frame, with PAD_VAL filling the border. Both sides use full valid/ready handshakes, so it sits between a conv/transconv layer and the next layer under backpressure. It replaces the fixed-size, valid-only padding used in the v3 generator.

## Interface
- DATA_WIDTH, 16, signed sample width (Q-format is transparent to this block)
- IMG_W, 8, input frame width in pixels (≥1)
- IMG_H, 8, input frame height in pixels (≥1)
- CHANNELS, 1, samples per pixel, channel index fastest (≥1)
- PAD, 1, border width on every side (≥0)
- PAD_VAL, 0, signed DATA_WIDTH constant emitted for border samples

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- valid_in  in  1  data_in carries a valid input sample
- ready_in  out  1  block accepts data_in this cycle (transfer = valid_in & ready_in)
- data_in  in  DATA_WIDTH  input sample, signed
- valid_out  out  1  data_out holds a valid output sample
- ready_out  in  1  downstream accepts data_out this cycle
- data_out  out  DATA_WIDTH  output sample, signed
- last_out  out  1  qualifies data_out as final sample of the padded frame
- busy  out  1  high while a frame is in progress

## Operation
- Output geometry: OW=IMG_W+2·PAD, OH=IMG_H+2·PAD. Order: row-major, column, channel innermost. Frame length N_OUT=OW·OH·CHANNELS. Input length N_IN=IMG_W·IMG_H·CHANNELS.
- Counters: ch (0..CHANNELS-1), col (0..OW-1), row (0..OH-1). They track the next output position to be loaded. Sized with $clog2 of their range, minimum 1 bit.
- Interior position: PAD ≤ col < PAD+IMG_W and PAD ≤ row < PAD+IMG_H. Every other position is border.
- FSM states:
  - IDLE: counters are zero and busy=0. valid_in=1 moves the FSM to ACTIVE without consuming the sample (ready_in=0 in IDLE).
  - ACTIVE: busy=1. Load condition: slot_free = !valid_out | ready_out.
    - Border position with slot_free: load PAD_VAL. No input consumed.
    - Interior position with slot_free and valid_in: ready_in=1, consume data_in, load it.
    - Interior position with valid_in=0: nothing is loaded. Border samples are never emitted ahead of missing interior data.
  - Each load advances ch→col→row with wrap. The load of position N_OUT-1 sets last_out and returns the FSM to IDLE on the same edge.
- ready_in = ACTIVE & interior & slot_free. It is combinational from state and ready_out only, never from valid_in.
- PAD=0 is a pure pass-through with registered output and correct last_out.
- The block has no arithmetic. Samples pass bit-exact.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, counters=0, valid_out=0, data_out=0, last_out=0, busy=0. A mid-frame reset discards the partial frame. The next valid_in after release starts a fresh frame at row 0.
- Output is registered. A sample loaded at edge k appears with valid_out=1 after edge k.
- data_out and last_out are held stable while valid_out=1 and ready_out=0.
- Start latency: valid_in first seen high in IDLE at edge t → ACTIVE after t → first output valid after edge t+1.
- Throughput: with ready_out=1 and valid_in=1 continuously, one output per cycle. A frame takes exactly N_OUT ACTIVE cycles.
- Back-to-back frames: there is exactly one IDLE bubble cycle between the last load of frame k and the first load of frame k+1.
- Extra input: input beyond N_IN of a frame waits, because ready_in=0 during border positions and IDLE. It is consumed by the next frame.

## Test plan
- IMG 4×4, C=1, PAD=1, PAD_VAL=0, inputs 1..16 continuous, ready_out=1:
  - Expect 36 outputs: 0×7, 1,2,3,4, 0,0, 5..8, 0,0, 9..12, 0,0, 13..16, 0×7.
  - last_out on output 36 only. First valid_out 2 cycles after valid_in rises.
- Same frame with ready_out toggling 1,0,0,1 repeating:
  - Identical 36-sample sequence. data_out stable across every stall.
  - ready_in never high while valid_out & !ready_out.
- Same frame with valid_in dropped for 3 cycles after sample 6:
  - valid_out stays low after sample 6 drains. No border zeros are emitted during the gap.
  - The sequence resumes with 7,8,0,0.
- IMG 2×2, C=2, PAD=1, PAD_VAL=-1 (0xFFFF), inputs 10..17:
  - Expect 32 outputs. Rows 0 and 3 are all -1.
  - Row 1: -1,-1,10,11,12,13,-1,-1.
- Reset asserted after 5 inputs of a 4×4 frame, then a full frame 1..16:
  - Outputs clear to 0 on the reset edge. The new frame output exactly matches scenario 1.
- Two frames back-to-back, PAD=0, 4×4:
  - 32 outputs equal to the inputs. last_out on outputs 16 and 32.
  - Exactly one bubble cycle between the frames.
